gate_sweep_unit: RTL and testbench

Parametrised successor to the team's two-input dataflow gates. It is a single N-input logic gate with selectable function, plus a sequencer that drives every input combination 0..2^N-1 through the gate. Each combination produces a registered output, and the complete truth table is captured into a register. It serves as on-chip self-stimulus for the gate library, replacing hand-written delay-driven stimulus sequences.

---
 rtl/gate_sweep_pkg.sv | 19 +
 rtl/gate_nin_df.sv | 27 ++
 rtl/gate_sweep_unit.sv | 125 ++++++++++++
 tb/tb_gate_sweep_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared gate-function and sweep-state encodings for the gate sweep unit.
package gate_sweep_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_BUF  = 3'd6;
    localparam logic [2:0] MODE_NOT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/gate_nin_df.sv
// Combinational N-input gate with selectable function, built from reduction operators.
module gate_nin_df
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] a,
    input  logic [2:0]      mode,
    output logic            y
);

    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_AND:  y = &a;
            MODE_OR:   y = |a;
            MODE_NAND: y = ~&a;
            MODE_NOR:  y = ~|a;
            MODE_XOR:  y = ^a;
            MODE_XNOR: y = ~^a;
            MODE_BUF:  y = a[0];
            MODE_NOT:  y = ~a[0];
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// Sweeps all 2^N_IN input patterns through an N-input gate and captures the truth table.
// Optional golden-table comparison is built when GATE_SWEEP_TRUTH_CHECK_EN is defined.
module gate_sweep_unit
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2,
    localparam int TT_W = 2**N_IN,
    localparam int CW   = $clog2(TT_W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic [N_IN-1:0] a,
    output logic            y,
    output logic            y_valid,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    input  logic [TT_W-1:0] expected_tt,
    output logic [CW-1:0]   mismatch_cnt,
    output logic            pass
);

    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [N_IN-1:0] ONE  = N_IN'(1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   a_q;
    logic [2:0]        mode_q;
    logic              y_q, yv_q;
    logic [TT_W-1:0]   tt_q;
    logic              f;
    logic              accept, last;

    gate_nin_df #(.N_IN(N_IN)) u_gate (
        .a    (a_q),
        .mode (mode_q),
        .y    (f)
    );

    assign accept = (state_q == ST_IDLE) && start;
    assign last   = (a_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (last)  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DRAIN);
    end

    // a_q wraps to 0 on the last pattern, which is exactly the value DRAIN presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            mode_q <= MODE_AND;
            y_q    <= 1'b0;
            yv_q   <= 1'b0;
            tt_q   <= '0;
        end else begin
            if (accept) begin
                mode_q <= mode;
                tt_q   <= '0;
            end
            if (state_q == ST_SWEEP) begin
                a_q       <= a_q + ONE;
                y_q       <= f;
                tt_q[a_q] <= f;
                yv_q      <= 1'b1;
            end else begin
                a_q  <= '0;
                yv_q <= 1'b0;
            end
        end
    end

    assign a       = a_q;
    assign y       = y_q;
    assign y_valid = yv_q;
    assign tt      = tt_q;

`ifdef GATE_SWEEP_TRUTH_CHECK_EN
    logic [TT_W-1:0] gold_q;
    logic [CW-1:0]   mcnt_q;
    logic            pass_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gold_q <= '0;
            mcnt_q <= '0;
            pass_q <= 1'b1;
        end else if (accept) begin
            gold_q <= expected_tt;
            mcnt_q <= '0;
            pass_q <= 1'b1;
        end else if (state_q == ST_SWEEP) begin
            if (f != gold_q[a_q]) mcnt_q <= mcnt_q + CW'(1);
        end else if (state_q == ST_DRAIN) begin
            pass_q <= (mcnt_q == '0);
        end
    end

    assign mismatch_cnt = mcnt_q;
    assign pass         = pass_q;
`else
    logic unused_expected;
    assign unused_expected = ^expected_tt;
    assign mismatch_cnt    = '0;
    assign pass            = 1'b1;
`endif

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit: one N_IN=2 and one N_IN=3 instance.
module tb_gate_sweep_unit;

`ifdef GATE_SWEEP_TRUTH_CHECK_EN
    localparam int   NAND_MC   = 2;
    localparam logic NAND_PASS = 1'b0;
`else
    localparam int   NAND_MC   = 0;
    localparam logic NAND_PASS = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0, start3 = 1'b0;
    logic [2:0] mode2 = 3'd0, mode3 = 3'd0;
    logic [3:0] gold2 = 4'd0;
    logic [7:0] gold3 = 8'h96;

    logic [1:0] a2;  logic y2, yv2, busy2, done2, pass2; logic [3:0] tt2; logic [2:0] mc2;
    logic [2:0] a3;  logic y3, yv3, busy3, done3, pass3; logic [7:0] tt3; logic [3:0] mc3;

    int checks = 0;
    int failures = 0;
    logic [31:0] s_a, s_y, s_v, s_b, s_d, s_t, s_m, s_p;

    gate_sweep_unit #(.N_IN(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .y(y2),
        .y_valid(yv2), .busy(busy2), .done(done2), .tt(tt2),
        .expected_tt(gold2), .mismatch_cnt(mc2), .pass(pass2)
    );

    gate_sweep_unit #(.N_IN(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .a(a3), .y(y3),
        .y_valid(yv3), .busy(busy3), .done(done3), .tt(tt3),
        .expected_tt(gold3), .mismatch_cnt(mc3), .pass(pass3)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input int n);
        if (n == 2) begin
            s_a = 32'(a2); s_y = 32'(y2); s_v = 32'(yv2); s_b = 32'(busy2);
            s_d = 32'(done2); s_t = 32'(tt2); s_m = 32'(mc2); s_p = 32'(pass2);
        end else begin
            s_a = 32'(a3); s_y = 32'(y3); s_v = 32'(yv3); s_b = 32'(busy3);
            s_d = 32'(done3); s_t = 32'(tt3); s_m = 32'(mc3); s_p = 32'(pass3);
        end
    endtask

    task automatic chk_reset(input int n);
        snap(n);
        chk("rst_a", s_a, 0);   chk("rst_y", s_y, 0);    chk("rst_yv", s_v, 0);
        chk("rst_busy", s_b, 0); chk("rst_done", s_d, 0); chk("rst_tt", s_t, 0);
        chk("rst_mc", s_m, 0);  chk("rst_pass", s_p, 1);
    endtask

    // Full sweep from IDLE; poke holds start high and forces mode to 0 while busy.
    task automatic sweep(input int n, input logic [2:0] m, input logic [7:0] exp,
                         input int emc, input logic epass, input bit poke);
        int tw;
        tw = 1 << n;
        if (n == 2) begin mode2 = m; start2 = 1'b1; end
        else        begin mode3 = m; start3 = 1'b1; end
        tick;
        if (n == 2) begin start2 = poke; if (poke) mode2 = 3'd0; end
        else        begin start3 = poke; if (poke) mode3 = 3'd0; end
        for (int k = 0; k <= tw; k++) begin
            snap(n);
            chk("sw_a", s_a, (k < tw) ? 32'(k) : 32'd0);
            chk("sw_busy", s_b, 1);
            chk("sw_done", s_d, 32'(k == tw));
            chk("sw_yv", s_v, 32'(k > 0));
            if (k > 0) chk("sw_y", s_y, 32'(exp[k-1]));
            if (k == 0) begin
                chk("sw_tt_clr", s_t, 0);
                chk("sw_mc_clr", s_m, 0);
                chk("sw_pass_start", s_p, 1);
            end
            tick;
        end
        start2 = 1'b0;
        start3 = 1'b0;
        snap(n);
        chk("end_busy", s_b, 0); chk("end_yv", s_v, 0); chk("end_done", s_d, 0);
        chk("end_tt", s_t, 32'(exp));
        chk("end_y", s_y, 32'(exp[tw-1]));
        chk("end_mc", s_m, 32'(emc));
        chk("end_pass", s_p, 32'(epass));
    endtask

    initial begin
        rst = 1'b1;
        tick; tick;
        chk_reset(2);
        chk_reset(3);
        rst = 1'b0;
        tick;

        gold2 = 4'b1110; sweep(2, 3'd1, 8'b0000_1110, 0, 1'b1, 1'b0);
        gold2 = 4'b1000; sweep(2, 3'd0, 8'b0000_1000, 0, 1'b1, 1'b1);
        gold2 = 4'b0101; sweep(2, 3'd7, 8'b0000_0101, 0, 1'b1, 1'b1);
        sweep(3, 3'd4, 8'b1001_0110, 0, 1'b1, 1'b1);

        // Reset while a=2: partial table must be discarded.
        gold2 = 4'b1110; mode2 = 3'd1; start2 = 1'b1;
        tick; start2 = 1'b0;
        tick; tick;
        chk("mid_a", 32'(a2), 2);
        chk("mid_tt", 32'(tt2), 32'b0010);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset(2);
        sweep(2, 3'd1, 8'b0000_1110, 0, 1'b1, 1'b0);

        // Back-to-back with start held high.
        gold2 = 4'b1110; mode2 = 3'd1; start2 = 1'b1;
        repeat (5) tick;
        chk("b2b_done", 32'(done2), 1);
        tick;
        chk("b2b_gap_busy", 32'(busy2), 0);
        chk("b2b_gap_tt", 32'(tt2), 32'b1110);
        tick;
        chk("b2b_busy2", 32'(busy2), 1);
        chk("b2b_tt_clr", 32'(tt2), 0);
        chk("b2b_a", 32'(a2), 0);
        start2 = 1'b0;
        repeat (5) tick;
        chk("b2b_end_busy", 32'(busy2), 0);
        chk("b2b_end_tt", 32'(tt2), 32'b1110);

        gold2 = 4'b1110; sweep(2, 3'd2, 8'b0000_0111, NAND_MC, NAND_PASS, 1'b0);
        gold2 = 4'b0111; sweep(2, 3'd2, 8'b0000_0111, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
